// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC fetch controller: FSM states and redirect kinds.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // Encoded so that a numerically larger kind has higher priority.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        ERET = 2'd2,
        EXC  = 2'd3
    } redir_kind_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect priority select (exception > eret > branch) plus a one-entry
// pending redirect held while an instruction fetch is still outstanding.
module pc_redirect_arb
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        use_pending,
    input  logic        capture,
    input  logic        clear,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] epc,
    output redir_kind_t sel_kind,
    output logic [31:0] sel_target
);

    redir_kind_t req_kind;
    logic [31:0] req_target;
    redir_kind_t pend_kind;
    logic [31:0] pend_target;

    always_comb begin
        req_kind   = NONE;
        req_target = br_target;
        if (exc_req) begin
            req_kind   = EXC;
            req_target = EXC_VECTOR;
        end else if (eret) begin
            req_kind   = ERET;
            req_target = epc;
        end else if (br_taken) begin
            req_kind   = BR;
            req_target = br_target;
        end
    end

    // A stored redirect wins over an equal- or lower-priority new request.
    always_comb begin
        sel_kind   = req_kind;
        sel_target = req_target;
        if (use_pending && (pend_kind != NONE) && (pend_kind >= req_kind)) begin
            sel_kind   = pend_kind;
            sel_target = pend_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_kind   <= NONE;
            pend_target <= 32'd0;
        end else if (clear) begin
            pend_kind   <= NONE;
        end else if (capture && (req_kind > pend_kind)) begin
            pend_kind   <= req_kind;
            pend_target <= req_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register load, runs the imem req/ack
// handshake, presents instructions to decode and applies redirects.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] epc,
    output state_t      state_dbg
);

    // Handshakes: a fetch completes in the cycle imem_req && imem_ack are both
    // high; an instruction transfers to decode in a cycle with instr_valid high
    // and stall low. A redirect ends the transfer even when stall is high.
    state_t      state;
    state_t      state_nx;
    redir_kind_t sel_kind;
    logic [31:0] sel_target;
    logic        in_fetch;
    logic        in_issue;
    logic        redirect;

    assign in_fetch  = (state == FETCH);
    assign in_issue  = (state == ISSUE);
    assign redirect  = (sel_kind != NONE);
    assign state_dbg = state;
    assign imem_addr = pc_cur;

    pc_redirect_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .use_pending (in_fetch),
        .capture     (in_fetch && !imem_ack),
        .clear       (in_fetch && imem_ack),
        .exc_req     (exc_req),
        .eret        (eret),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .epc         (epc),
        .sel_kind    (sel_kind),
        .sel_target  (sel_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = FETCH;
            FETCH:   if (imem_ack && !redirect) state_nx = ISSUE;
            ISSUE:   if (!stall || redirect) state_nx = FETCH;
            default: state_nx = BOOT;
        endcase
    end

    always_comb begin
        pc_ena      = 1'b0;
        pc_next     = START_ADDR;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                pc_next  = redirect ? sel_target : pc_cur + INSTR_BYTES;
                pc_ena   = imem_ack && redirect;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                pc_next     = redirect ? sel_target : pc_cur + INSTR_BYTES;
                pc_ena      = !stall || redirect;
            end
            default: ;
        endcase
    end

    // epc records the instruction being faulted: the presented one in ISSUE,
    // the one being fetched in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_pc <= START_ADDR;
            epc      <= START_ADDR;
        end else begin
            if (in_fetch && imem_ack && !redirect) begin
                instr_pc <= pc_cur;
            end
            if (exc_req && in_issue) begin
                epc <= instr_pc;
            end else if (exc_req && in_fetch) begin
                epc <= pc_cur;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed stimulus, a behavioural model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_pc_fetch_ctrl;
    import pc_ctrl_pkg::*;

    localparam logic [31:0] START = 32'h00400000;
    localparam logic [31:0] EXCV  = 32'h00400004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_cur;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc;
    state_t      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // PC register of the surrounding datapath, with a back door for forcing.
    logic [31:0] pc_reg = START;
    logic        force_pc = 1'b0;
    logic [31:0] force_val = 32'd0;

    assign pc_cur = pc_reg;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_ena      (pc_ena),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .state_dbg   (state_dbg)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= START;
        else if (force_pc) pc_reg <= force_val;
        else if (pc_ena) pc_reg <= pc_next;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting after reset, 1 = fetching, 2 = presenting.
    // Pending redirect priority 0..3 (none, branch, eret, exception).
    int          m_ph = 0, nx_ph = 0;
    logic [31:0] m_ipc = START, nx_ipc = START;
    logic [31:0] m_epc = START, nx_epc = START;
    int          m_pk = 0, nx_pk = 0;
    logic [31:0] m_pt = 0, nx_pt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_ipc <= START; m_epc <= START; m_pk <= 0; m_pt <= 32'd0;
        end else begin
            m_ph <= nx_ph; m_ipc <= nx_ipc; m_epc <= nx_epc; m_pk <= nx_pk; m_pt <= nx_pt;
        end
    end

    always @(negedge clk) begin
        int          rp, ek;
        logic [31:0] rt, et, e_next;
        logic        e_req, e_val, e_ena;
        if (chk_en) begin
            rp = exc_req ? 3 : eret ? 2 : br_taken ? 1 : 0;
            rt = exc_req ? EXCV : eret ? m_epc : br_target;
            e_req = 1'b0; e_val = 1'b0; e_ena = 1'b0; e_next = START;
            nx_ph = m_ph; nx_ipc = m_ipc; nx_epc = m_epc; nx_pk = m_pk; nx_pt = m_pt;
            if (!rst) begin
                if (m_ph == 0) begin
                    nx_ph = 1;
                end else if (m_ph == 1) begin
                    e_req = 1'b1;
                    if (m_pk != 0 && m_pk >= rp) begin ek = m_pk; et = m_pt; end
                    else begin ek = rp; et = rt; end
                    if (exc_req) nx_epc = pc_cur;
                    if (imem_ack) begin
                        nx_pk = 0;
                        if (ek != 0) begin e_ena = 1'b1; e_next = et; end
                        else begin nx_ph = 2; nx_ipc = pc_cur; end
                    end else if (rp > m_pk) begin
                        nx_pk = rp; nx_pt = rt;
                    end
                end else begin
                    e_val = 1'b1;
                    if (exc_req) nx_epc = m_ipc;
                    if (rp != 0) begin e_ena = 1'b1; e_next = rt; end
                    else if (!stall) begin e_ena = 1'b1; e_next = pc_cur + 32'd4; end
                    if (e_ena) nx_ph = 1;
                end
            end
            chk("m_imem_req", {31'd0, imem_req}, {31'd0, e_req});
            chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, e_val});
            chk("m_pc_ena", {31'd0, pc_ena}, {31'd0, e_ena});
            if (e_req) chk("m_imem_addr", imem_addr, pc_cur);
            if (e_ena || m_ph == 0) chk("m_pc_next", pc_next, e_next);
            chk("m_instr_pc", instr_pc, m_ipc);
            chk("m_epc", epc, m_epc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #3;
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_ena", {31'd0, pc_ena}, 32'd0);
        chk("rst_pc_next", pc_next, 32'h00400000);
        chk("rst_instr_pc", instr_pc, 32'h00400000);
        chk("rst_epc", epc, 32'h00400000);
        chk("rst_state", {30'd0, state_dbg}, {30'd0, BOOT});

        // Zero-wait fetch stream
        rst = 1'b0;
        imem_ack = 1'b1;
        settle();
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        chk("boot_ena", {31'd0, pc_ena}, 32'd0);
        step();
        chk("seq_addr0", imem_addr, 32'h00400000);
        step();
        chk("seq_valid0", {31'd0, instr_valid}, 32'd1);
        chk("seq_ena0", {31'd0, pc_ena}, 32'd1);
        chk("seq_next0", pc_next, 32'h00400004);
        step();
        chk("seq_addr1", imem_addr, 32'h00400004);
        step();
        step();
        chk("seq_addr2", imem_addr, 32'h00400008);
        step(); step(); step(); step();
        chk("seq_addr4", imem_addr, 32'h00400010);

        // Stall held for 3 cycles in ISSUE
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_ipc", instr_pc, 32'h00400010);
            chk("stall_ena", {31'd0, pc_ena}, 32'd0);
        end
        stall = 1'b0;
        settle();
        chk("unstall_ena", {31'd0, pc_ena}, 32'd1);
        chk("unstall_next", pc_next, 32'h00400014);

        // Branch while the fetch is outstanding
        step();
        imem_ack = 1'b0;
        br_taken = 1'b1;
        br_target = 32'h00400100;
        settle();
        chk("br_wait_ena", {31'd0, pc_ena}, 32'd0);
        step();
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("br_wait_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        imem_ack = 1'b1;
        settle();
        chk("br_ack_ena", {31'd0, pc_ena}, 32'd1);
        chk("br_ack_next", pc_next, 32'h00400100);
        chk("br_ack_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("br_addr", imem_addr, 32'h00400100);

        // Branch with ack in FETCH: discard and refetch
        br_taken = 1'b1;
        br_target = 32'h00400020;
        settle();
        chk("brack_next", pc_next, 32'h00400020);
        chk("brack_valid", {31'd0, instr_valid}, 32'd0);
        step();
        br_taken = 1'b0;
        chk("brack_addr", imem_addr, 32'h00400020);

        // Exception in ISSUE, then ERET
        step();
        exc_req = 1'b1;
        settle();
        chk("exc_next", pc_next, 32'h00400004);
        chk("exc_ena", {31'd0, pc_ena}, 32'd1);
        step();
        exc_req = 1'b0;
        chk("exc_epc", epc, 32'h00400020);
        chk("exc_addr", imem_addr, 32'h00400004);
        step();
        eret = 1'b1;
        settle();
        chk("eret_next", pc_next, 32'h00400020);
        step();
        eret = 1'b0;
        step(); step(); step();
        chk("pre_all_ipc", instr_pc, 32'h00400024);

        // All three redirects in the same cycle
        exc_req = 1'b1;
        eret = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h00400300;
        settle();
        chk("all_next", pc_next, 32'h00400004);
        step();
        exc_req = 1'b0; eret = 1'b0; br_taken = 1'b0;
        chk("all_epc", epc, 32'h00400024);

        // Pending exception not displaced by a later branch
        imem_ack = 1'b0;
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        imem_ack = 1'b1;
        settle();
        chk("pend_ena", {31'd0, pc_ena}, 32'd1);
        chk("pend_next", pc_next, 32'h00400004);
        chk("pend_epc", epc, 32'h00400004);
        step();

        // PC+4 wraps at the top of the address space
        imem_ack = 1'b0;
        force_val = 32'hFFFFFFFC;
        force_pc = 1'b1;
        step();
        force_pc = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
        imem_ack = 1'b1;
        step();
        chk("wrap_ipc", instr_pc, 32'hFFFFFFFC);
        chk("wrap_next", pc_next, 32'h00000000);
        step();
        chk("wrap_addr2", imem_addr, 32'h00000000);

        // Reset in the middle of a fetch
        imem_ack = 1'b0;
        settle();
        rst = 1'b1;
        #1;
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_ena", {31'd0, pc_ena}, 32'd0);
        chk("mrst_next", pc_next, 32'h00400000);
        chk("mrst_ipc", instr_pc, 32'h00400000);
        chk("mrst_epc", epc, 32'h00400000);
        imem_ack = 1'b1;
        step(); step();
        rst = 1'b0;
        settle();
        chk("mrst_boot_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_boot_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("mrst_addr", imem_addr, 32'h00400000);
        step(); step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the enable and next-value inputs of the CPU's PC register (start address 0x00400000). It runs the instruction-memory request/acknowledge handshake and holds the PC during pipeline stalls. It selects the next PC from a fixed priority of sources: exception vector, ERET return, branch/jump target, or sequential PC+4. Sits between the PC register, instruction memory and the decode/control unit.

Parameters:
START_ADDR, 32'h00400000, PC value after reset; also the reset value of epc
EXC_VECTOR, 32'h00400004, exception handler entry address

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
pc_cur  in  32  current output of the PC register
pc_ena  out  1  load enable to the PC register
pc_next  out  32  data input to the PC register
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (equals pc_cur)
imem_ack  in  1  fetch data valid this cycle
instr_valid  out  1  fetched instruction is presented to decode
instr_pc  out  32  PC of the presented instruction
stall  in  1  decode cannot accept; hold the current instruction
br_taken  in  1  branch/jump redirect request
br_target  in  32  branch/jump target
exc_req  in  1  exception request
eret  in  1  return from exception
epc  out  32  saved exception PC

Behaviour:
- Reset values (asynchronous): state=BOOT, pc_ena=0, pc_next=START_ADDR, imem_req=0, instr_valid=0, instr_pc=START_ADDR, epc=START_ADDR, pending redirect cleared. Reset asserted mid-fetch or mid-stall aborts immediately; an outstanding ack after reset is ignored in BOOT.
- States:
  - BOOT: outputs idle for 1 cycle, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc_cur.
    - On imem_ack with no redirect (pending or same-cycle): go to ISSUE and latch instr_pc=pc_cur.
    - On imem_ack with a redirect: discard the instruction, pc_ena=1 for 1 cycle, pc_next=target, clear pending, stay in FETCH.
  - ISSUE: instr_valid=1.
    - stall=1 and no redirect: hold; pc_ena=0.
    - stall=0 or any redirect: pc_ena=1, pc_next=selected source, go to FETCH.
- Redirect priority: exc_req > eret > br_taken > PC+4.
  - Targets: EXC_VECTOR, epc, br_target.
  - A redirect overrides stall.
- Pending redirect: a redirect seen in FETCH without ack is stored in a 1-entry register (kind + target). A later, higher-priority request replaces it; a lower or equal one is ignored. The stored entry is applied on the next ack.
- epc capture: on exc_req, epc <= instr_pc in ISSUE, or pc_cur in FETCH. exc_req and eret in the same cycle: exception wins and epc is updated.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFFFFFC -> 0x00000000). No alignment checks.
- pc_ena is never asserted in BOOT. At most one PC load occurs per instruction issued or discarded.
- Latency: 0-wait memory gives one instruction per 2 cycles (FETCH, ISSUE).

Decomposition:
- Shared package pc_ctrl_pkg: state enum (BOOT, FETCH, ISSUE), redirect-kind enum (NONE, BR, ERET, EXC), constant INSTR_BYTES=4.
- One natural sub-module, pc_redirect_arb: combinational priority select plus the pending-redirect register.

Test Plan:
- Reset release, imem_ack=1 every cycle -> imem_addr 0x00400000, 0x00400004, 0x00400008; instr_valid every 2nd cycle; first pc_ena 2 cycles after BOOT exit.
- stall=1 for 3 cycles in ISSUE at PC 0x00400010 -> instr_valid held, instr_pc=0x00400010, pc_ena=0; after release pc_next=0x00400014.
- br_taken=1, br_target=0x00400100 while imem_ack held low for 4 cycles -> no instr_valid for the in-flight fetch; on ack pc_next=0x00400100; next imem_addr=0x00400100.
- exc_req at ISSUE, instr_pc=0x00400020 -> epc=0x00400020, pc_next=0x00400004; later eret -> pc_next=0x00400020.
- exc_req, eret and br_taken in the same cycle -> pc_next=EXC_VECTOR, epc updated; pending exception not replaced by a later br_taken.
- pc_cur forced to 0xFFFFFFFC, sequential issue -> pc_next=0x00000000; assert rst mid-FETCH -> all outputs reset values in the same cycle.
